// File: rtl/a0_uart_tx_pkg.sv
// Shared types and constants for the a0 UART readout path.
package a0_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int         BYTES_PER_WORD = 4;
  localparam logic [7:0] SYNC_BYTE      = 8'hA5;

  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    word_byte = word[7:0];
      2'd1:    word_byte = word[15:8];
      2'd2:    word_byte = word[23:16];
      default: word_byte = word[31:24];
    endcase
  endfunction

endpackage

// File: rtl/a0_uart_tx_byte.sv
// One 8N1 byte on the line; a load on the done cycle chains the next byte with no idle gap.
//
// state | meaning
// IDLE  | line held high, waiting for load
// START | start bit (0) on the line
// DATA  | eight data bits, LSB first
// STOP  | stop bit (1); done pulses in its last cycle
module uart_byte_tx
  import a0_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_end;

  assign bit_end = (baud_cnt == '0);
  assign done    = (state == STOP) && bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else if (load && (state == IDLE || done)) begin
      state    <= START;
      tx       <= 1'b0;
      baud_cnt <= CNT_TOP;
      bit_idx  <= '0;
      shreg    <= data;
    end else begin
      // Down-counter reloads on terminal count so every bit lasts CLKS_PER_BIT cycles.
      if (state != IDLE) baud_cnt <= bit_end ? CNT_TOP : baud_cnt - 1'b1;
      case (state)
        START: if (bit_end) begin
          state <= DATA;
          tx    <= shreg[0];
          shreg <= {1'b0, shreg[7:1]};
        end
        DATA: if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            tx    <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
          end
          bit_idx <= bit_idx + 1'b1;
        end
        STOP: if (bit_end) begin
          state <= IDLE;
          tx    <= 1'b1;
        end
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/a0_uart_tx.sv
// Sends each new a0 value as four little-endian 8N1 bytes; A0_UART_TX_SYNC_BYTE_EN
// prefixes every word with a 0xA5 sync byte.
module a0_uart_tx
  import a0_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a0,
  output logic                  tx,
  output logic                  busy,
  output logic                  ovf
);

`ifdef A0_UART_TX_SYNC_BYTE_EN
  localparam int NBYTES = BYTES_PER_WORD + 1;
  localparam int IDX_W  = 3;
`else
  localparam int NBYTES = BYTES_PER_WORD;
  localparam int IDX_W  = 2;
`endif

  logic [DATA_WIDTH-1:0] shadow, word, pend, next_word;
  logic                  pend_v;
  logic [IDX_W-1:0]      byte_idx, next_idx;
  logic [7:0]            next_byte;
  logic                  u_done, change, byte_done, last_byte, frame_end;
  logic                  start_pend, start_a0, pend_cap, load;

  assign change     = en && (a0 != shadow);
  assign byte_done  = busy && u_done;
  assign last_byte  = (byte_idx == IDX_W'(NBYTES - 1));
  assign frame_end  = byte_done && last_byte;
  // A pending word is consumed first, so a change on that same edge becomes the new pending word.
  assign start_pend = frame_end && pend_v;
  assign start_a0   = change && (!busy || (frame_end && !pend_v));
  assign pend_cap   = change && busy && !start_a0;
  assign load       = start_pend || start_a0 || (byte_done && !last_byte);
  assign next_word  = start_pend ? pend : (start_a0 ? a0 : word);
  assign next_idx   = (start_pend || start_a0) ? '0 : byte_idx + 1'b1;

  always_comb begin
    next_byte = 8'h00;
`ifdef A0_UART_TX_SYNC_BYTE_EN
    if (next_idx == '0) next_byte = SYNC_BYTE;
    else                next_byte = word_byte(next_word, 2'(next_idx - 3'd1));
`else
    next_byte = word_byte(next_word, next_idx);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow   <= '0;
      word     <= '0;
      pend     <= '0;
      pend_v   <= 1'b0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      byte_idx <= '0;
    end else begin
      if (change) shadow <= a0;
      if (load) begin
        word     <= next_word;
        byte_idx <= next_idx;
      end
      if (start_pend || start_a0) busy <= 1'b1;
      else if (frame_end)         busy <= 1'b0;
      if (pend_cap) begin
        pend   <= a0;
        pend_v <= 1'b1;
        if (pend_v && !frame_end) ovf <= 1'b1;
      end else if (start_pend) begin
        pend_v <= 1'b0;
      end
    end
  end

  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .data (next_byte),
    .tx   (tx),
    .done (u_done)
  );

endmodule

// File: tb/tb_a0_uart_tx.sv
// Bench for a0_uart_tx: line decoder, cycle-level reference model, vector table and corner sequences.
module tb_a0_uart_tx;

  localparam int C = 4;
`ifdef A0_UART_TX_SYNC_BYTE_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int FRAME = NB * 10 * C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [31:0] a0  = 32'h0;
  logic        tx, busy, ovf;

  a0_uart_tx #(.DATA_WIDTH(32), .CLKS_PER_BIT(C)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .a0   (a0),
    .tx   (tx),
    .busy (busy),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: frame occupancy as cycle arithmetic, bytes queued at frame start.
  int          cyc = 0;
  bit          m_active = 0, m_pend_v = 0, m_ovf = 0;
  int          m_end = 0;
  logic [31:0] m_shadow = 0, m_pend = 0;
  logic [7:0]  exp_q[$];

  task automatic model_send(input logic [31:0] w);
    m_active = 1;
    m_end    = cyc + FRAME;
    for (int i = 0; i < NB - 4; i++) exp_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_pend_v = 0; m_ovf = 0; m_shadow = 0;
      exp_q.delete();
    end else begin
      cyc++;
      if (m_active && cyc == m_end) begin
        if (m_pend_v) begin
          m_pend_v = 0;
          model_send(m_pend);
        end else m_active = 0;
      end
      if (en && a0 != m_shadow) begin
        m_shadow = a0;
        if (!m_active) model_send(a0);
        else begin
          if (m_pend_v) m_ovf = 1;
          m_pend   = a0;
          m_pend_v = 1;
        end
      end
    end
  end

  // Line decoder and busy/ovf trace monitor, sampled on the falling edge.
  logic [7:0] rx_q[$];
  int  rx_total = 0, frame_err = 0, busy_mm = 0, ovf_mm = 0;
  int  run = 0, last_run = 0, dec_cnt = 0;
  bit  dec_on = 0;
  logic [7:0] dec_bits;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      dec_on = 0;
      run    = 0;
    end else begin
      if (busy !== m_active) busy_mm++;
      if (ovf !== m_ovf) ovf_mm++;
      if (busy) run++;
      else if (run != 0) begin
        last_run = run;
        run      = 0;
      end
      if (!dec_on) begin
        if (tx === 1'b0) begin
          dec_on  = 1;
          dec_cnt = 0;
        end
      end else begin
        dec_cnt++;
        if (dec_cnt % C == 0) begin
          if (dec_cnt / C <= 8) dec_bits[dec_cnt/C-1] = tx;
          else begin
            if (tx !== 1'b1) frame_err++;
            rx_q.push_back(dec_bits);
            rx_total++;
            dec_on = 0;
          end
        end
      end
    end
  end

  task automatic drive(input logic e, input logic [31:0] v);
    @(negedge clk);
    en = e;
    a0 = v;
  endtask

  task automatic capture_check(input string name);
    @(posedge clk);
    #1;
    check({name, "_tx"}, tx, 0);
    check({name, "_busy"}, busy, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 6 * FRAME) begin
      n++;
      @(negedge clk);
    end
    check("idle_wait", 32'(n < 6 * FRAME), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_tail(input string name, input logic [31:0] w);
    int base;
    logic [7:0] e;
    check({name, "_len"}, 32'(rx_q.size() >= NB), 1);
    if (rx_q.size() >= NB) begin
      base = rx_q.size() - NB;
      for (int i = 0; i < NB; i++) begin
        e = (i < NB - 4) ? 8'hA5 : w[8*(i-(NB-4)) +: 8];
        check($sformatf("%s_b%0d", name, i), rx_q[base+i], e);
      end
    end
  endtask

  task automatic check_queues(input string name);
    int n;
    check({name, "_count"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", name, i), rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic        en;
    logic [31:0] a0;
    int          gap;
    int          frames;
    logic        ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0000, 200,        0, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_00FF, FRAME + 20, 1, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_00FF, 50,         1, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0007, 200,        1, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0007, FRAME + 20, 2, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_0000, FRAME + 20, 3, 1'b0};

    repeat (3) @(negedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].en, vecs[i].a0);
      repeat (vecs[i].gap) @(negedge clk);
      check($sformatf("vec%0d_bytes", i), rx_total, vecs[i].frames * NB);
      check($sformatf("vec%0d_busy", i), busy, 0);
      check($sformatf("vec%0d_tx", i), tx, 1);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
    end
    check_queues("vec");

    drive(1'b1, 32'h1234_5678);
    capture_check("cap1");
    wait_idle();
    check("single_run", last_run, FRAME);
    check_tail("single", 32'h1234_5678);
    check_queues("single");

    drive(1'b1, 32'h1111_1111);
    repeat (60) @(negedge clk);
    a0 = 32'hAAAA_0001;
    wait_idle();
    check("b2b_run", last_run, 2 * FRAME);
    check("b2b_ovf", ovf, 0);
    check_tail("b2b", 32'hAAAA_0001);
    check_queues("b2b");

    drive(1'b1, 32'h2222_2222);
    repeat (30) @(negedge clk);
    a0 = 32'h1;
    repeat (30) @(negedge clk);
    a0 = 32'h2;
    repeat (30) @(negedge clk);
    a0 = 32'h3;
    wait_idle();
    check("ovf_run", last_run, 2 * FRAME);
    check("ovf_set", ovf, 1);
    check_tail("ovf", 32'h3);
    repeat (100) @(negedge clk);
    check("ovf_sticky", ovf, 1);
    check_queues("ovf");

    drive(1'b0, 32'h5);
    repeat (100) @(negedge clk);
    check("en_low_busy", busy, 0);
    check("en_low_tx", tx, 1);
    drive(1'b1, 32'h5);
    capture_check("en_rise");
    wait_idle();
    check("en_run", last_run, FRAME);
    check_tail("en", 32'h5);
    check_queues("en");

    drive(1'b1, 32'h0BAD_F00D);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_ovf", ovf, 0);
    rx_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    capture_check("post_rst");
    wait_idle();
    check("post_rst_run", last_run, FRAME);
    check_tail("post_rst", 32'h0BAD_F00D);
    check_queues("post_rst");

    for (int it = 0; it < 300; it++) begin
      logic        e;
      logic [31:0] v;
      e = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = 32'($urandom_range(0, 3));
        2:       v = a0;
        default: v = a0 ^ 32'h1;
      endcase
      drive(e, v);
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    en = 1'b1;
    wait_idle();
    wait_idle();
    check("rand_busy_trace", busy_mm, 0);
    check("rand_ovf_trace", ovf_mm, 0);
    check("stop_bits", frame_err, 0);
    check_queues("rand");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
